// File: rtl/key_classifier_pkg.sv
// Shared types and scan-code constants for the PS/2 key classifier.
package key_classifier_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXT,
    ST_BRK,
    ST_EXT_BRK
  } state_e;

  typedef enum logic [2:0] {
    CLS_NONE,
    CLS_T,
    CLS_P,
    CLS_B,
    CLS_INI,
    CLS_TER
  } class_e;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_T1    = 8'h16;
  localparam logic [7:0] SC_T2    = 8'h1E;
  localparam logic [7:0] SC_T3    = 8'h26;
  localparam logic [7:0] SC_P1    = 8'h4D;
  localparam logic [7:0] SC_P0    = 8'h21;
  localparam logic [7:0] SC_B1    = 8'h32;
  localparam logic [7:0] SC_B0    = 8'h31;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_Q     = 8'h15;

  // One-hot position of a class in the {terminar, iniciar, b, p, t} mask.
  function automatic logic [4:0] class_mask(input class_e c);
    case (c)
      CLS_T:   class_mask = 5'b00001;
      CLS_P:   class_mask = 5'b00010;
      CLS_B:   class_mask = 5'b00100;
      CLS_INI: class_mask = 5'b01000;
      CLS_TER: class_mask = 5'b10000;
      default: class_mask = 5'b00000;
    endcase
  endfunction

endpackage

// File: rtl/key_classifier_key_lut.sv
// Combinational decode of {extended, scan code} into key class and value.
module key_lut
  import key_classifier_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic              ext,
  input  logic [DATA_W-1:0] code,
  output class_e            cls,
  output logic [1:0]        val
);

  // Only Enter exists in the extended set; everything else decodes plain.
  always_comb begin
    cls = CLS_NONE;
    val = '0;
    if (ext) begin
      if (code == DATA_W'(SC_ENTER)) cls = CLS_TER;
    end else begin
      case (code)
        DATA_W'(SC_T1):    begin cls = CLS_T;   val = 2'd1; end
        DATA_W'(SC_T2):    begin cls = CLS_T;   val = 2'd2; end
        DATA_W'(SC_T3):    begin cls = CLS_T;   val = 2'd3; end
        DATA_W'(SC_P1):    begin cls = CLS_P;   val = 2'd1; end
        DATA_W'(SC_P0):    begin cls = CLS_P;   val = 2'd0; end
        DATA_W'(SC_B1):    begin cls = CLS_B;   val = 2'd1; end
        DATA_W'(SC_B0):    begin cls = CLS_B;   val = 2'd0; end
        DATA_W'(SC_ENTER): cls = CLS_TER;
        DATA_W'(SC_Q):     cls = CLS_INI;
        default:           cls = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/key_classifier.sv
// PS/2 scan-code sequencer: tracks E0/F0 prefixes, classifies keys,
// emits one-cycle class pulses and maintains a per-class held mask.
module key_classifier
  import key_classifier_pkg::*;
#(
  parameter int unsigned REPORT_ON_BREAK = 0,
  parameter int unsigned SUPPRESS_REPEAT = 1,
  parameter int unsigned TIMEOUT_CYC     = 50000,
  parameter int unsigned DATA_W          = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              validat,
  output logic              validap,
  output logic              validab,
  output logic              iniciar,
  output logic              terminar,
  output logic [1:0]        key_val,
  output logic [4:0]        held
);

  localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);

  state_e           state_q, state_d, state_cur;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [4:0]       pulse_q, pulse_d;
  logic [1:0]       key_val_q, key_val_d;
  logic [4:0]       held_q, held_d;

  logic       timeout;
  logic       ev_make, ev_brk, ev_ext;
  logic       fire;
  logic [4:0] mask;
  class_e     lut_cls;
  logic [1:0] lut_val;

  key_lut #(.DATA_W(DATA_W)) u_lut (
    .ext  (ev_ext),
    .code (rx_data),
    .cls  (lut_cls),
    .val  (lut_val)
  );

  // Prefix tracking; an expiring timeout collapses the state to IDLE first,
  // so a byte arriving on that same cycle is parsed from IDLE.
  always_comb begin
    timeout   = (state_q != ST_IDLE) && (cnt_q == CNT_MAX);
    state_cur = timeout ? ST_IDLE : state_q;
    state_d   = state_cur;
    cnt_d     = '0;
    ev_make   = 1'b0;
    ev_brk    = 1'b0;
    ev_ext    = 1'b0;
    if (rx_valid) begin
      case (state_cur)
        ST_IDLE: begin
          if (rx_data == DATA_W'(SC_EXT))      state_d = ST_EXT;
          else if (rx_data == DATA_W'(SC_BRK)) state_d = ST_BRK;
          else                                 ev_make = 1'b1;
        end
        ST_EXT: begin
          if (rx_data == DATA_W'(SC_BRK)) begin
            state_d = ST_EXT_BRK;
          end else begin
            ev_make = 1'b1;
            ev_ext  = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          ev_brk  = 1'b1;
          state_d = ST_IDLE;
        end
        ST_EXT_BRK: begin
          ev_brk  = 1'b1;
          ev_ext  = 1'b1;
          state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_cur != ST_IDLE) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Apply make/break events to the held mask, pulses and key value.
  always_comb begin
    mask      = class_mask(lut_cls);
    held_d    = held_q;
    pulse_d   = '0;
    key_val_d = key_val_q;
    fire      = 1'b0;
    if (ev_make) begin
      held_d = held_q | mask;
      fire   = (REPORT_ON_BREAK == 0) &&
               !((SUPPRESS_REPEAT != 0) && ((held_q & mask) != '0));
    end else if (ev_brk) begin
      held_d = held_q & ~mask;
      fire   = (REPORT_ON_BREAK != 0);
    end
    if (fire && (mask != '0)) begin
      pulse_d   = mask;
      key_val_d = lut_val;
    end
  end

  // State, timeout counter and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      pulse_q   <= '0;
      key_val_q <= '0;
      held_q    <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pulse_q   <= pulse_d;
      key_val_q <= key_val_d;
      held_q    <= held_d;
    end
  end

  assign validat  = pulse_q[0];
  assign validap  = pulse_q[1];
  assign validab  = pulse_q[2];
  assign iniciar  = pulse_q[3];
  assign terminar = pulse_q[4];
  assign key_val  = key_val_q;
  assign held     = held_q;

endmodule

// File: tb/tb_key_classifier.sv
// Directed vector bench for key_classifier: a make-on-press instance with
// repeat suppression and a report-on-break instance share the stimulus.
module tb_key_classifier;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;

  logic       t0, p0, b0, i0, e0;
  logic [1:0] kv0;
  logic [4:0] h0;
  logic       t1, p1, b1, i1, e1;
  logic [1:0] kv1;
  logic [4:0] h1;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  key_classifier #(.TIMEOUT_CYC(16)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .validat(t0), .validap(p0), .validab(b0), .iniciar(i0), .terminar(e0),
    .key_val(kv0), .held(h0)
  );

  key_classifier #(.REPORT_ON_BREAK(1), .SUPPRESS_REPEAT(0), .TIMEOUT_CYC(16)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .validat(t1), .validap(p1), .validab(b1), .iniciar(i1), .terminar(e1),
    .key_val(kv1), .held(h1)
  );

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic [4:0] p;   // expected {terminar, iniciar, b, p, t}
    logic [1:0] kv;
    logic [4:0] h;
  } vec_t;

  vec_t tbl[$];

  task automatic row(input logic v, input logic [7:0] d, input logic [4:0] p,
                     input logic [1:0] kv, input logic [4:0] h);
    vec_t r;
    r.v = v; r.d = d; r.p = p; r.kv = kv; r.h = h;
    tbl.push_back(r);
  endtask

  // One byte per cycle: present at negedge, sample 1 time unit after posedge.
  task automatic drive(input logic v, input logic [7:0] d);
    @(negedge clk);
    rx_valid = v;
    rx_data  = d;
    @(posedge clk);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic chk(input string nm, input logic [4:0] ap, input logic [1:0] ak,
                     input logic [4:0] ah, input logic [4:0] ep, input logic [1:0] ek,
                     input logic [4:0] eh);
    n_vec++;
    if (ap !== ep || ak !== ek || ah !== eh) begin
      n_err++;
      $display("FAIL %s: pulses=%b key_val=%0d held=%b, expected pulses=%b key_val=%0d held=%b",
               nm, ap, ak, ah, ep, ek, eh);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset0", {e0, i0, b0, p0, t0}, kv0, h0, 5'b0, 2'd0, 5'b0);
    chk("reset1", {e1, i1, b1, p1, t1}, kv1, h1, 5'b0, 2'd0, 5'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Make/break, repeats, per-class suppression, extended and prefix corners.
    row(1, 8'h1E, 5'b00001, 2'd2, 5'b00001);
    row(0, 8'h00, 5'b00000, 2'd2, 5'b00001);
    row(1, 8'hF0, 5'b00000, 2'd2, 5'b00001);
    row(1, 8'h1E, 5'b00000, 2'd2, 5'b00000);
    row(1, 8'h16, 5'b00001, 2'd1, 5'b00001);
    row(1, 8'h16, 5'b00000, 2'd1, 5'b00001);
    row(1, 8'h16, 5'b00000, 2'd1, 5'b00001);
    row(1, 8'hF0, 5'b00000, 2'd1, 5'b00001);
    row(1, 8'h16, 5'b00000, 2'd1, 5'b00000);
    row(0, 8'h16, 5'b00000, 2'd1, 5'b00000);
    row(1, 8'h4D, 5'b00010, 2'd1, 5'b00010);
    row(1, 8'h21, 5'b00000, 2'd1, 5'b00010);
    row(1, 8'hF0, 5'b00000, 2'd1, 5'b00010);
    row(1, 8'h4D, 5'b00000, 2'd1, 5'b00000);
    row(1, 8'h21, 5'b00010, 2'd0, 5'b00010);
    row(1, 8'hF0, 5'b00000, 2'd0, 5'b00010);
    row(1, 8'h21, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'h32, 5'b00100, 2'd1, 5'b00100);
    row(1, 8'hF0, 5'b00000, 2'd1, 5'b00100);
    row(1, 8'h32, 5'b00000, 2'd1, 5'b00000);
    row(1, 8'h31, 5'b00100, 2'd0, 5'b00100);
    row(1, 8'hF0, 5'b00000, 2'd0, 5'b00100);
    row(1, 8'h31, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'h26, 5'b00001, 2'd3, 5'b00001);
    row(1, 8'hF0, 5'b00000, 2'd3, 5'b00001);
    row(1, 8'h26, 5'b00000, 2'd3, 5'b00000);
    row(1, 8'hE0, 5'b00000, 2'd3, 5'b00000);
    row(1, 8'h5A, 5'b10000, 2'd0, 5'b10000);
    row(1, 8'hE0, 5'b00000, 2'd0, 5'b10000);
    row(1, 8'hF0, 5'b00000, 2'd0, 5'b10000);
    row(1, 8'h5A, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'h5A, 5'b10000, 2'd0, 5'b10000);
    row(1, 8'hF0, 5'b00000, 2'd0, 5'b10000);
    row(1, 8'h5A, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'hE0, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'h75, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'h1E, 5'b00001, 2'd2, 5'b00001);
    row(1, 8'hE0, 5'b00000, 2'd2, 5'b00001);
    row(1, 8'hF0, 5'b00000, 2'd2, 5'b00001);
    row(1, 8'h1E, 5'b00000, 2'd2, 5'b00001);
    row(1, 8'hF0, 5'b00000, 2'd2, 5'b00001);
    row(1, 8'h1E, 5'b00000, 2'd2, 5'b00000);
    row(1, 8'hE0, 5'b00000, 2'd2, 5'b00000);
    row(1, 8'h16, 5'b00000, 2'd2, 5'b00000);
    row(1, 8'hF0, 5'b00000, 2'd2, 5'b00000);
    row(1, 8'hF0, 5'b00000, 2'd2, 5'b00000);
    row(1, 8'h16, 5'b00001, 2'd1, 5'b00001);
    row(1, 8'hF0, 5'b00000, 2'd1, 5'b00001);
    row(1, 8'h16, 5'b00000, 2'd1, 5'b00000);
    row(1, 8'hE0, 5'b00000, 2'd1, 5'b00000);
    row(1, 8'hE0, 5'b00000, 2'd1, 5'b00000);
    row(1, 8'h15, 5'b01000, 2'd0, 5'b01000);
    row(1, 8'hF0, 5'b00000, 2'd0, 5'b01000);
    row(1, 8'h15, 5'b00000, 2'd0, 5'b00000);
    row(1, 8'h1C, 5'b00000, 2'd0, 5'b00000);

    foreach (tbl[i]) begin
      drive(tbl[i].v, tbl[i].d);
      chk($sformatf("vec%0d", i), {e0, i0, b0, p0, t0}, kv0, h0,
          tbl[i].p, tbl[i].kv, tbl[i].h);
    end

    // Break arriving one cycle before the timeout still counts as a break.
    drive(1, 8'h15);
    chk("to_make", {e0, i0, b0, p0, t0}, kv0, h0, 5'b01000, 2'd0, 5'b01000);
    drive(1, 8'hF0);
    repeat (15) drive(0, 8'h00);
    drive(1, 8'h15);
    chk("to_late_break", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00000, 2'd0, 5'b00000);

    // Full timeout: the byte colliding with expiry is decoded as a make.
    drive(1, 8'hF0);
    repeat (16) drive(0, 8'h00);
    chk("to_wait", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00000, 2'd0, 5'b00000);
    drive(1, 8'h15);
    chk("to_expire", {e0, i0, b0, p0, t0}, kv0, h0, 5'b01000, 2'd0, 5'b01000);
    drive(1, 8'hF0);
    drive(1, 8'h15);
    chk("to_clear", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00000, 2'd0, 5'b00000);

    // Reset in the middle of a break sequence.
    drive(1, 8'h1E);
    chk("rst_pre", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00001, 2'd2, 5'b00001);
    drive(1, 8'hF0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00000, 2'd0, 5'b00000);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_hold0", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00000, 2'd0, 5'b00000);
    chk("rst_hold1", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00000, 2'd0, 5'b00000);
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 8'h31);
    chk("rst_post", {e0, i0, b0, p0, t0}, kv0, h0, 5'b00100, 2'd0, 5'b00100);

    // Report-on-break instance, starting clean.
    do_reset();
    drive(1, 8'h4D);
    chk("rob_make", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00000, 2'd0, 5'b00010);
    drive(1, 8'hF0);
    chk("rob_pref", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00000, 2'd0, 5'b00010);
    drive(1, 8'h4D);
    chk("rob_break", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00010, 2'd1, 5'b00000);
    drive(0, 8'h00);
    chk("rob_once", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00000, 2'd1, 5'b00000);
    drive(1, 8'hF0);
    drive(1, 8'h32);
    chk("rob_unheld", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00100, 2'd1, 5'b00000);
    drive(1, 8'h26);
    drive(1, 8'h26);
    chk("rob_repeat", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00000, 2'd1, 5'b00001);
    drive(1, 8'hF0);
    drive(1, 8'h26);
    chk("rob_t3", {e1, i1, b1, p1, t1}, kv1, h1, 5'b00001, 2'd3, 5'b00000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
